// File: rtl/multiply_pkg.sv
// Shared definitions for the iterative signed multiplier: FSM state
// encoding and the default operand width.
package multiply_pkg;

    localparam int MULT_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mult_state_t;

endpackage : multiply_pkg

// File: rtl/multiply_abs.sv
// Two's-complement magnitude and sign extraction. The magnitude is treated
// as unsigned, so the most negative input maps to 2^(W-1) exactly.
module multiply_abs #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_value,
    output logic [W-1:0] o_magnitude,
    output logic         o_sign
);

    // Negate negative inputs; the unsigned reading of the result is the magnitude
    always_comb begin
        o_sign      = i_value[W-1];
        o_magnitude = i_value[W-1] ? (~i_value + {{(W-1){1'b0}}, 1'b1}) : i_value;
    end

endmodule : multiply_abs

// File: rtl/multiply.sv
// Iterative signed WIDTH x WIDTH -> 2*WIDTH shift-and-add multiplier behind a
// level-held mult_begin / mult_end handshake. One partial product per clock
// on operand magnitudes; the result sign is applied on the final iteration.
// Optional build macro: MULT_EARLY_TERM_EN -- finish as soon as the remaining
// multiplier bits are all zero instead of always running WIDTH iterations.
module multiply
    import multiply_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mult_begin,
    input  logic [WIDTH-1:0]     mult_op1,
    input  logic [WIDTH-1:0]     mult_op2,
    output logic [2*WIDTH-1:0]   product,
    output logic                 mult_end
);

    localparam int                CNT_W     = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(WIDTH - 1);

    mult_state_t          r_state;
    mult_state_t          w_stateNext;

    logic [2*WIDTH-1:0]   r_multiplicand;
    logic [WIDTH-1:0]     r_multiplier;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]     r_count;
    logic                 r_sign;

    logic [WIDTH-1:0]     w_mag1;
    logic [WIDTH-1:0]     w_mag2;
    logic                 w_sign1;
    logic                 w_sign2;
    logic [2*WIDTH-1:0]   w_addend;
    logic [2*WIDTH-1:0]   w_accSum;
    logic [2*WIDTH-1:0]   w_signedResult;
    logic                 w_lastIter;

    multiply_abs #(.W(WIDTH)) u_absOp1 (
        .i_value     (mult_op1),
        .o_magnitude (w_mag1),
        .o_sign      (w_sign1)
    );

    multiply_abs #(.W(WIDTH)) u_absOp2 (
        .i_value     (mult_op2),
        .o_magnitude (w_mag2),
        .o_sign      (w_sign2)
    );

    // Partial product, running sum and the signed form of that sum for the final step
    always_comb begin
        w_addend       = r_multiplier[0] ? r_multiplicand : '0;
        w_accSum       = r_acc + w_addend;
        w_signedResult = r_sign ? (~w_accSum + {{(2*WIDTH-1){1'b0}}, 1'b1}) : w_accSum;
`ifdef MULT_EARLY_TERM_EN
        w_lastIter     = (r_multiplier[WIDTH-1:1] == '0) || (r_count == LAST_ITER);
`else
        w_lastIter     = (r_count == LAST_ITER);
`endif
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic; dropping mult_begin always returns to IDLE
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE: begin
                if (mult_begin) begin
                    w_stateNext = BUSY;
                end
            end
            BUSY: begin
                if (!mult_begin) begin
                    w_stateNext = IDLE;
                end else if (w_lastIter) begin
                    w_stateNext = DONE;
                end
            end
            DONE: begin
                if (!mult_begin) begin
                    w_stateNext = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // Output decode straight from the state register so mult_end is glitch-free
    always_comb begin
        mult_end = (r_state == DONE);
    end

    // Datapath: latch magnitudes on start, then one shift-and-add per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_multiplicand <= '0;
            r_multiplier   <= '0;
            r_acc          <= '0;
            r_count        <= '0;
            r_sign         <= 1'b0;
            product        <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (mult_begin) begin
                        r_multiplicand <= {{WIDTH{1'b0}}, w_mag1};
                        r_multiplier   <= w_mag2;
                        r_sign         <= w_sign1 ^ w_sign2;
                        r_acc          <= '0;
                        r_count        <= '0;
                    end
                end
                BUSY: begin
                    if (mult_begin) begin
                        r_acc          <= w_accSum;
                        r_multiplicand <= r_multiplicand << 1;
                        r_multiplier   <= r_multiplier >> 1;
                        r_count        <= r_count + CNT_W'(1);
                        if (w_lastIter) begin
                            product <= w_signedResult;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule : multiply

// File: tb/tb_multiply.sv
// Directed testbench for the iterative signed multiplier: reset state, several
// signed products, exact handshake latency, abort and mid-operation reset.
// Honours MULT_EARLY_TERM_EN when computing the expected latency.
module tb_multiply;

    logic        clk;
    logic        rst;
    logic        mult_begin;
    logic [31:0] mult_op1;
    logic [31:0] mult_op2;
    logic [63:0] product;
    logic        mult_end;

    int checkCount;
    int failCount;
    logic [63:0] lastProduct;

    multiply #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .mult_begin (mult_begin),
        .mult_op1   (mult_op1),
        .mult_op2   (mult_op2),
        .product    (product),
        .mult_end   (mult_end)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Cycle count from the start request until mult_end is first seen high
    function automatic int expectedLatency(input logic [31:0] op2);
`ifdef MULT_EARLY_TERM_EN
        logic [31:0] mag;
        int hi;
        mag = op2[31] ? (~op2 + 32'd1) : op2;
        hi = 0;
        for (int i = 0; i < 32; i++) begin
            if (mag[i]) hi = i;
        end
        return hi + 2;
`else
        return 33;
`endif
    endfunction

    // Full operation: hold mult_begin for 40 cycles, scramble operands mid-run,
    // then release and confirm mult_end drops while product holds
    task automatic applyStimulus(input string tag, input logic [31:0] op1, input logic [31:0] op2,
                                 input logic [63:0] expected);
        int firstSeen;
        firstSeen = 0;
        @(negedge clk);
        mult_op1   = op1;
        mult_op2   = op2;
        mult_begin = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (mult_end && firstSeen == 0) firstSeen = c;
            if (c == 5) begin
                mult_op1 = 32'h5A5A_A5A5;
                mult_op2 = 32'h8765_4321;
            end
        end
        checkOutput({tag, "_latency"}, 64'(firstSeen), 64'(expectedLatency(op2)));
        checkOutput({tag, "_product"}, product, expected);
        checkOutput({tag, "_endHigh"}, {63'd0, mult_end}, 64'd1);
        mult_begin = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_endLow"}, {63'd0, mult_end}, 64'd0);
        checkOutput({tag, "_hold"}, product, expected);
        lastProduct = expected;
    endtask

    // Main directed sequence
    initial begin
        checkCount  = 0;
        failCount   = 0;
        lastProduct = 64'd0;
        rst         = 1'b1;
        mult_begin  = 1'b0;
        mult_op1    = 32'd0;
        mult_op2    = 32'd0;

        repeat (2) @(negedge clk);
        checkOutput("reset_product", product, 64'd0);
        checkOutput("reset_end", {63'd0, mult_end}, 64'd0);
        rst = 1'b0;

        applyStimulus("sq1111",   32'h0000_1111, 32'h0000_1111, 64'h0000_0000_0123_4321);
        applyStimulus("m2222",    32'h0000_1111, 32'h0000_2222, 64'h0000_0000_0246_8642);
        applyStimulus("twoNeg1",  32'h0000_0002, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE);
        applyStimulus("twoNegX",  32'h0000_0002, 32'hFFFF_DB77, 64'hFFFF_FFFF_FFFF_B6EE);
        applyStimulus("minSq",    32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        applyStimulus("neg1Sq",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
        applyStimulus("zeroNeg",  32'h0000_0000, 32'hFFFF_FFFF, 64'h0000_0000_0000_0000);
        applyStimulus("negPos",   32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB);

        // Abort: drop mult_begin at cycle 10, result must never appear
        @(negedge clk);
        mult_op1   = 32'h0000_0003;
        mult_op2   = 32'h0000_0005;
        mult_begin = 1'b1;
        repeat (10) @(negedge clk);
        mult_begin = 1'b0;
        begin
            int sawEnd;
            sawEnd = 0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (mult_end) sawEnd = 1;
            end
            checkOutput("abort_end", 64'(sawEnd), 64'd0);
        end
        checkOutput("abort_product", product, lastProduct);

        // Reset in the middle of an operation
        @(negedge clk);
        mult_op1   = 32'h0000_0003;
        mult_op2   = 32'h0000_0005;
        mult_begin = 1'b1;
        repeat (10) @(negedge clk);
        rst        = 1'b1;
        mult_begin = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midReset_product", product, 64'd0);
        checkOutput("midReset_end", {63'd0, mult_end}, 64'd0);

        // A fresh operation after reset must run with normal latency from IDLE
        applyStimulus("afterReset", 32'h0000_0003, 32'h0000_0005, 64'h0000_0000_0000_000F);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule : tb_multiply

// File: doc/multiply.md
Name: multiply

Overview:
- Iterative signed 32x32 -> 64-bit shift-and-add multiplier.
- Used as a multi-cycle execution unit behind a level-held start handshake (`mult_begin` / `mult_end`).
- One partial-product step per clock: converts operands to magnitudes, accumulates, then applies the result sign.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH bits; iteration count equals WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- mult_begin  in  1  start request, level-held high for the whole operation.
- mult_op1  in  WIDTH  signed two's-complement multiplicand.
- mult_op2  in  WIDTH  signed two's-complement multiplier.
- product  out  2*WIDTH  signed two's-complement result.
- mult_end  out  1  result valid; high while in DONE.

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, product=0, mult_end=0, internal registers cleared. Reset overrides everything, including mid-operation.
- IDLE:
  - On an edge with mult_begin=1: latch |mult_op1| into a 2*WIDTH multiplicand register (zero-extended).
  - Latch |mult_op2| into a WIDTH multiplier register.
  - Latch sign = op1[MSB] XOR op2[MSB], clear accumulator and iteration counter, go to BUSY.
  - Operands are sampled only on this edge; later changes are ignored.
- BUSY, one iteration per edge:
  - If multiplier[0]=1, add multiplicand to accumulator.
  - Shift multiplicand left 1 and multiplier right 1; increment counter.
  - After the WIDTH-th iteration go to DONE. On that same edge, product = sign ? -acc : acc (2*WIDTH two's complement).
- DONE: mult_end=1; product holds.
- Abort and restart:
  - mult_begin=0 in BUSY or DONE returns to IDLE on that edge; mult_end is low from the next cycle.
  - A new operation requires mult_begin low for at least one cycle, so no auto-restart while held high.
- Latency: mult_end rises WIDTH+1 edges after the edge on which mult_begin is first sampled high (33 cycles at WIDTH=32). Holding mult_begin 40 cycles is sufficient.
- product holds its last value through IDLE and is replaced only when the next result completes. An aborted operation does not update product.
- Magnitude rules:
  - Magnitudes are unsigned WIDTH-bit, so -2^(WIDTH-1) is represented exactly.
  - The accumulator is 2*WIDTH bits and never overflows.
  - Zero operands give product 0 with sign ignored, never negative zero.
- mult_end is a registered-state decode (state==DONE), glitch-free.

Optional Feature:
- Macro: MULT_EARLY_TERM_EN.
- Defined: BUSY goes to DONE on the edge where the post-shift multiplier becomes zero, with a minimum of 1 iteration. Latency = (index of highest set bit of |mult_op2|)+2 cycles; |mult_op2|=0 gives 2 cycles. Results are identical.
- Undefined: fixed WIDTH iterations as above.

Decomposition:
- Package multiply_pkg: state enum (IDLE, BUSY, DONE) and MULT_WIDTH_DEFAULT=32.
- One natural sub-module, multiply_abs: combinational two's-complement magnitude and sign extraction, instantiated twice.
- Counter, accumulator and FSM stay in the top.

Test Plan:
- rst=1 for 2 cycles -> product=0, mult_end=0.
- Hold mult_begin for 40 cycles with op1=0x00001111, op2=0x00001111 -> mult_end high exactly 33 cycles after start, product=0x0000000001234321. Then mult_begin low -> mult_end low the next cycle, product holds.
- op1=0x00001111, op2=0x00002222 -> 0x0000000002468642.
- op1=0x00000002, op2=0xFFFFFFFF -> 0xFFFFFFFFFFFFFFFE.
- op1=0x00000002, op2=0xFFFFDB77 -> 0xFFFFFFFFFFFFB6EE.
- op1=op2=0x80000000 -> 0x4000000000000000.
- Abort and reset mid-operation:
  - Drop mult_begin at cycle 10 -> mult_end stays 0, product unchanged.
  - Assert rst at cycle 10 -> product=0 and state=IDLE.
